div_result_collector: RTL
=========================

Name: div_result_collector

Overview:
- Sits directly downstream of the interleaved hex long-divider and consumes its per-iteration quotient-digit stream.
- Keeps two accumulation slots that match the divider's two interleaved calculations.
- Assembles each 4-digit fractional quotient together with its operands and queues the finished result in a small FIFO.
- Presents results on a valid/ready interface to the checker/printer stage.

Parameters:
DEPTH, 4, result FIFO entries (power of 2, >=2)
CNT_W, 3, width of occupancy count; must hold 0..DEPTH

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
dig_valid  in  1  digit beat valid (one beat max per cycle)
dig_slot  in  1  interleave slot of the beat (divider's odd/even tag)
dig_iter  in  2  iteration index 0..3
dig_value  in  8  quotient digit; bits [7:4] must be 0
dig_aa  in  4  dividend A; sampled only when dig_iter==0
dig_bb  in  4  divisor B; sampled only when dig_iter==0
res_valid  out  1  FIFO head valid
res_ready  in  1  consumer accepts head
res_aa  out  4  head dividend
res_bb  out  4  head divisor
res_quotient  out  16  head quotient, digit0 in [15:12], digit3 in [3:0]
res_error  out  1  head result saw a digit with nonzero [7:4]
count  out  CNT_W  FIFO occupancy
seq_error  out  1  sticky: out-of-sequence beat seen
overflow  out  1  sticky: completed result dropped because FIFO full
err_clr  in  1  synchronous clear of seq_error and overflow

Behaviour:
- Reset (async assert, sync-safe deassert): both slots idle, accumulators/operands/flags 0, FIFO empty, res_valid=0, count=0, seq_error=0, overflow=0. Outputs res_aa/bb/quotient/error read 0 while empty.
- Per-slot state: busy, exp_iter[1:0], acc[15:0], aa, bb, err.
- Beat with dig_iter==0 on slot s:
  - acc={12'b0,dig_value[3:0]}, aa=dig_aa, bb=dig_bb, err=(dig_value[7:4]!=0), busy=1, exp_iter=1.
  - If slot s was already busy, the old partial result is discarded and seq_error is set.
- Beat with dig_iter!=0 on slot s:
  - Valid only if busy and dig_iter==exp_iter.
  - When valid: acc={acc[11:0],dig_value[3:0]}, err|=(dig_value[7:4]!=0), exp_iter++.
  - When not valid: seq_error=1, slot returns to idle, beat ignored.
- Accepted beat with dig_iter==3 completes the slot:
  - Push {aa,bb,acc_next,err_next} into the FIFO on the same edge; slot goes idle.
  - res_valid rises the cycle after the completing edge if the FIFO was empty (latency 1).
- The other slot is never affected by a beat for slot s. Interleaved beats on alternating cycles are the normal case.
- FIFO:
  - First-word-fall-through, in-order.
  - Pop occurs when res_valid && res_ready.
  - res_valid = (count!=0).
- Push while full:
  - If a pop happens the same cycle, both occur and count is unchanged.
  - Otherwise the result is dropped, overflow=1, and FIFO contents are unchanged.
- Push and pop in the same cycle at a non-full count: count is unchanged and the head advances.
- Pointers wrap modulo DEPTH. count saturates at neither end; push and pop are gated by full and empty.
- err_clr clears the sticky flags. If a new error occurs the same cycle, the new error wins (flag stays 1).
- Reset mid-operation: partial slots and all queued results are lost and nothing is emitted afterwards. The first beat accepted after reset must have dig_iter==0.
- dig_value[3:0] is passed through unmodified. No range check against B; the checker does that.

Test Plan:
- Slot0 beats iter0..3 with digits 5,5,5,5, A=1, B=3, res_ready=1 -> one cycle after the iter3 edge: res_valid=1, res_quotient=16'h5555, res_aa=1, res_bb=3, res_error=0; popped next edge, count back to 0.
- Interleave slot0 (A=7,B=8, digits E,0,0,0) and slot1 (A=2,B=5, digits 6,6,6,6) on alternating cycles -> two results in completion order: 16'hE000 then 16'h6666; seq_error=0.
- res_ready=0, complete 5 results -> count=4, overflow=1, 5th dropped. Then res_ready=1 -> first 4 drain in order. err_clr -> overflow=0.
- Slot0 iter0 then iter2 (iter1 skipped) -> seq_error=1, nothing enqueued. Following full iter0..3 sequence enqueues normally.
- Digit beat dig_value=8'h13 at iter1 -> completed result has res_error=1, res_quotient nibble1=3.
- Assert reset_n=0 after iter1 with one result queued -> res_valid=0 and count=0 immediately (async). After release, an iter2 beat sets seq_error=1.

Source files
------------

// File: rtl/div_result_collector_if.sv
// div_result_collector_if
//   Bundles the quotient-digit stream coming from the interleaved hex
//   long-divider and the result/status stream going to the checker stage.
//   master : producer side (divider + consumer), drives digits, res_ready, err_clr
//   slave  : collector side, drives the FIFO head, occupancy and sticky flags
interface div_result_collector_if #(
  parameter int CNT_W = 3
);
  logic             dig_valid;
  logic             dig_slot;
  logic [1:0]       dig_iter;
  logic [7:0]       dig_value;
  logic [3:0]       dig_aa;
  logic [3:0]       dig_bb;
  logic             res_valid;
  logic             res_ready;
  logic [3:0]       res_aa;
  logic [3:0]       res_bb;
  logic [15:0]      res_quotient;
  logic             res_error;
  logic [CNT_W-1:0] count;
  logic             seq_error;
  logic             overflow;
  logic             err_clr;

  modport master (
    output dig_valid, dig_slot, dig_iter, dig_value, dig_aa, dig_bb,
    output res_ready, err_clr,
    input  res_valid, res_aa, res_bb, res_quotient, res_error,
    input  count, seq_error, overflow
  );

  modport slave (
    input  dig_valid, dig_slot, dig_iter, dig_value, dig_aa, dig_bb,
    input  res_ready, err_clr,
    output res_valid, res_aa, res_bb, res_quotient, res_error,
    output count, seq_error, overflow
  );
endinterface

// File: rtl/div_result_collector.sv
// div_result_collector
//   Collects the per-iteration quotient digits of the interleaved hex
//   long-divider into two accumulation slots (one per interleave slot),
//   assembles each 4-digit quotient with its operands and queues the
//   finished result in a first-word-fall-through FIFO.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : div_result_collector_if.slave
//              dig_*  digit beats in, res_* valid/ready result head out,
//              count occupancy, seq_error/overflow sticky flags, err_clr clear
module div_result_collector #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  div_result_collector_if.slave bus
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // A digit beat is malformed when its upper nibble is nonzero.
  function automatic logic digit_err_f(input logic [7:0] value);
    return (value[7:4] != 4'h0);
  endfunction

  // Per-slot accumulation state
  logic [1:0]  busy_r;
  logic [1:0]  exp_iter_r [2];
  logic [15:0] acc_r      [2];
  logic [3:0]  aa_r       [2];
  logic [3:0]  bb_r       [2];
  logic [1:0]  err_r;

  // Result FIFO state
  logic [3:0]       mem_aa_r  [DEPTH];
  logic [3:0]       mem_bb_r  [DEPTH];
  logic [15:0]      mem_q_r   [DEPTH];
  logic             mem_err_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             valid_r;
  logic             seq_error_r;
  logic             overflow_r;

  // Beat classification
  logic        start_s;
  logic        adv_s;
  logic        abort_s;
  logic        seq_evt_s;
  logic        complete_s;
  logic [15:0] sel_acc_s;
  logic [15:0] acc_next_s;
  logic        err_next_s;

  // FIFO control
  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic             ovf_evt_s;
  logic [CNT_W-1:0] count_next_s;

  // Classify the incoming beat against the addressed slot's expected iteration.
  always_comb begin
    start_s   = 1'b0;
    adv_s     = 1'b0;
    abort_s   = 1'b0;
    seq_evt_s = 1'b0;
    if (bus.dig_valid) begin
      if (bus.dig_iter == 2'd0) begin
        start_s   = 1'b1;
        // Restarting a busy slot throws away its partial result.
        seq_evt_s = busy_r[bus.dig_slot];
      end else if (busy_r[bus.dig_slot] && (bus.dig_iter == exp_iter_r[bus.dig_slot])) begin
        adv_s = 1'b1;
      end else begin
        abort_s   = 1'b1;
        seq_evt_s = 1'b1;
      end
    end else begin
      start_s = 1'b0;
    end
  end

  assign complete_s = adv_s && (bus.dig_iter == 2'd3);
  assign sel_acc_s  = acc_r[bus.dig_slot];
  assign acc_next_s = {sel_acc_s[11:0], bus.dig_value[3:0]};
  assign err_next_s = err_r[bus.dig_slot] | digit_err_f(bus.dig_value);

  assign full_s    = (count_r == FULL_CNT);
  assign pop_s     = valid_r && bus.res_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_s    = complete_s && (!full_s || pop_s);
  assign ovf_evt_s = complete_s && full_s && !pop_s;

  // Next occupancy from the push/pop pair.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      2'b01:   count_next_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
      default: count_next_s = count_r;
    endcase
  end

  // Slot accumulators: only the slot named by the beat is touched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r <= 2'b00;
      err_r  <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        exp_iter_r[i] <= 2'd0;
        acc_r[i]      <= 16'h0000;
        aa_r[i]       <= 4'h0;
        bb_r[i]       <= 4'h0;
      end
    end else if (start_s) begin
      busy_r[bus.dig_slot]     <= 1'b1;
      exp_iter_r[bus.dig_slot] <= 2'd1;
      acc_r[bus.dig_slot]      <= {12'h000, bus.dig_value[3:0]};
      aa_r[bus.dig_slot]       <= bus.dig_aa;
      bb_r[bus.dig_slot]       <= bus.dig_bb;
      err_r[bus.dig_slot]      <= digit_err_f(bus.dig_value);
    end else if (adv_s) begin
      busy_r[bus.dig_slot]     <= !complete_s;
      exp_iter_r[bus.dig_slot] <= exp_iter_r[bus.dig_slot] + 2'd1;
      acc_r[bus.dig_slot]      <= acc_next_s;
      err_r[bus.dig_slot]      <= err_next_s;
    end else if (abort_s) begin
      busy_r[bus.dig_slot] <= 1'b0;
    end else begin
      busy_r <= busy_r;
    end
  end

  // Result FIFO storage, pointers, occupancy and sticky status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_aa_r[i]  <= 4'h0;
        mem_bb_r[i]  <= 4'h0;
        mem_q_r[i]   <= 16'h0000;
        mem_err_r[i] <= 1'b0;
      end
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      valid_r     <= 1'b0;
      seq_error_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      if (push_s) begin
        mem_aa_r[wr_ptr_r]  <= aa_r[bus.dig_slot];
        mem_bb_r[wr_ptr_r]  <= bb_r[bus.dig_slot];
        mem_q_r[wr_ptr_r]   <= acc_next_s;
        mem_err_r[wr_ptr_r] <= err_next_s;
        wr_ptr_r            <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      count_r <= count_next_s;
      valid_r <= (count_next_s != {CNT_W{1'b0}});
      // A fresh event outranks a clear in the same cycle.
      if (seq_evt_s) begin
        seq_error_r <= 1'b1;
      end else if (bus.err_clr) begin
        seq_error_r <= 1'b0;
      end
      if (ovf_evt_s) begin
        overflow_r <= 1'b1;
      end else if (bus.err_clr) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Head fields read as zero while the FIFO is empty.
  assign bus.res_valid    = valid_r;
  assign bus.res_aa       = valid_r ? mem_aa_r[rd_ptr_r]  : 4'h0;
  assign bus.res_bb       = valid_r ? mem_bb_r[rd_ptr_r]  : 4'h0;
  assign bus.res_quotient = valid_r ? mem_q_r[rd_ptr_r]   : 16'h0000;
  assign bus.res_error    = valid_r ? mem_err_r[rd_ptr_r] : 1'b0;
  assign bus.count        = count_r;
  assign bus.seq_error    = seq_error_r;
  assign bus.overflow     = overflow_r;

endmodule
